seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 9 +
 rtl/div_sub_stage.sv | 12 +
 rtl/seq_divider.sv | 70 +++++++
 tb/tb_seq_divider.sv | 137 +++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared width default, FSM states and counter sizing for the divider
package seq_divider_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W = $clog2(DEF_WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/div_sub_stage.sv
// div_sub_stage: a + ~b + cin with carry-out, used as the restoring-division trial subtract
module div_sub_stage #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock, MSB first
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_width(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvd, dsr;
  logic [WIDTH:0] part, shifted, trial, part_n;
  logic cout, accept, last, zero_div;
  assign accept = start && state != RUN;
  assign last = cnt == CW'(WIDTH - 1);
  assign zero_div = divisor == '0;
  assign shifted = (part << 1) | (WIDTH + 1)'(dvd[WIDTH-1]);
  assign part_n = cout ? trial : shifted;
  div_sub_stage #(.WIDTH(WIDTH + 1)) u_sub (
    .a(shifted),
    .b({1'b0, dsr}),
    .cin(1'b1),
    .sum(trial),
    .cout(cout)
  );
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_n;
  always_comb begin
    state_n = state == RUN ? (last ? DONE : RUN) : accept ? (zero_div ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
  end
  // dvd shifts the dividend out of its MSB while quotient bits fill in from the LSB
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      dvd <= '0;
      dsr <= '0;
      part <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      dvd <= dividend;
      dsr <= divisor;
      part <= '0;
      quotient <= zero_div ? '1 : '0;
      remainder <= zero_div ? dividend : '0;
      div_by_zero <= zero_div;
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      dvd <= {dvd[WIDTH-2:0], cout};
      part <= part_n;
      if (last) begin
        quotient <= {dvd[WIDTH-2:0], cout};
        remainder <= part_n[WIDTH-1:0];
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench; expectations queued at start, checked on each done pulse
module tb_seq_divider;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          n;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, checks = 0, errors = 0;
  seq_divider dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (done) begin : mon
      exp_t e;
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.z);
        check("done_cycle", cyc, e.n);
        check("busy_in_done", busy, 0);
      end
    end
  task automatic go(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.q = (b == 0) ? 32'hFFFFFFFF : a / b;
    e.r = (b == 0) ? a : a % b;
    e.z = (b == 0);
    e.n = cyc + ((b == 0) ? 0 : 32);
    sb.push_back(e);
    start = 1'b0;
  endtask
  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("timeout", sb.size(), 0);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_q"}, quotient, 0);
    check({tag, "_r"}, remainder, 0);
    check({tag, "_dbz"}, div_by_zero, 0);
  endtask
  initial begin
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    go(100, 7);
    @(negedge clk);
    check("busy_run", busy, 1);
    check("done_run", done, 0);
    wait_done();
    go(32'hFFFFFFFF, 1);
    wait_done();
    repeat (3) @(negedge clk);
    check("q_hold", quotient, 32'hFFFFFFFF);
    go(3, 10);
    wait_done();
    go(5, 0);
    @(negedge clk);
    check("dbz_busy", busy, 0);
    wait_done();
    go(100, 7);
    repeat (9) @(posedge clk);
    #1;
    dividend = 9;
    divisor = 3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    go(100, 7);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check_zero("midrun_rst");
    repeat (40) @(negedge clk);
    go(9, 3);
    wait_done();
    go(100, 7);
    for (k = 0; k < 100 && !done; k++) @(negedge clk);
    check("b2b_reached", done, 1);
    go(50, 6);
    @(negedge clk);
    check("b2b_busy", busy, 1);
    wait_done();
    for (int i = 0; i < 8; i++) begin
      go($urandom, (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom);
      wait_done();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
